// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: slice width, FSM encoding
// and the elaboration-time width check.
package nibble_serial_adder_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Legal widths are whole, non-empty multiples of the slice width.
    function automatic bit width_ok(input int w);
        return (w >= NIB_W) && ((w % NIB_W) == 0);
    endfunction

endpackage

// File: rtl/nibble_serial_adder_slice.sv
// Purely combinational 4-bit ripple-carry adder slice with carry-in/carry-out.
module nibble_add_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    always_comb begin
        logic c;
        sum = '0;
        c   = cin;
        for (int i = 0; i < 4; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder built from one 4-bit slice, walking the operands one nibble
// per clock, LSB nibble first, with a registered inter-nibble carry.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NIB   = WIDTH / NIB_W;
    localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIB - 1);

    if (!width_ok(WIDTH)) begin : g_width_check
        $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 4");
    end

    // Handshake: a request is taken on any edge where start=1 and busy=0
    // (IDLE or DONE); while busy=1 start and all operand inputs are ignored.
    // done pulses for one cycle exactly when sum/cout take the new result.
    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;

    logic [NIB_W-1:0]   slice_a, slice_b, slice_sum;
    logic               slice_cout;
    int                 nib_lo;

    always_comb begin
        nib_lo  = int'(cnt_q) * NIB_W;
        slice_a = a_q[nib_lo +: NIB_W];
        slice_b = b_q[nib_lo +: NIB_W];
    end

    nibble_add_slice u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    res_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                res_d[nib_lo +: NIB_W] = slice_sum;
                carry_d                = slice_cout;
                if (cnt_q == LAST_CNT) begin
                    // Publish only the fully assembled word, never a partial one.
                    sum_d   = res_d;
                    cout_d  = slice_cout;
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder: a 16-bit and a 4-bit instance on one
// clock, hand-computed expected values checked with immediate assertions.
module tb_nibble_serial_adder;

    logic        clk;
    logic        rst;

    logic        start16, cin16, busy16, done16, cout16;
    logic [15:0] a16, b16, sum16;

    logic        start4, cin4, busy4, done4, cout4;
    logic [3:0]  a4, b4, sum4;

    int n_cmp;
    int n_fail;

    nibble_serial_adder #(.WIDTH(16)) dut16 (
        .clk   (clk),
        .rst   (rst),
        .start (start16),
        .a     (a16),
        .b     (b16),
        .cin   (cin16),
        .busy  (busy16),
        .done  (done16),
        .sum   (sum16),
        .cout  (cout16)
    );

    nibble_serial_adder #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst   (rst),
        .start (start4),
        .a     (a4),
        .b     (b4),
        .cin   (cin4),
        .busy  (busy4),
        .done  (done4),
        .sum   (sum4),
        .cout  (cout4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    int          n_dones;
    int          done_cyc [2];
    logic [15:0] done_sum [2];
    logic        done_cout[2];

    initial begin
        n_cmp   = 0;
        n_fail  = 0;
        rst     = 1'b1;
        start16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
        start4  = 1'b0; a4  = '0; b4  = '0; cin4  = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        check("rst_busy16", busy16, 0);
        check("rst_done16", done16, 0);
        check("rst_sum16",  sum16,  0);
        check("rst_cout16", cout16, 0);
        check("rst_busy4",  busy4,  0);
        check("rst_done4",  done4,  0);

        // FFFF + 0001 + 0: full carry ripple, 4 RUN cycles
        a16 = 16'hFFFF; b16 = 16'h0001; cin16 = 1'b0; start16 = 1'b1;
        step();
        start16 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("ripple_run_busy", busy16, 1);
            check("ripple_run_done", done16, 0);
            check("ripple_run_sum_held", sum16, 0);
            step();
        end
        check("ripple_done", done16, 1);
        check("ripple_busy_at_done", busy16, 0);
        check("ripple_sum", sum16, 16'h0000);
        check("ripple_cout", cout16, 1);
        step();
        check("ripple_done_falls", done16, 0);
        check("ripple_sum_hold", sum16, 16'h0000);
        check("ripple_cout_hold", cout16, 1);

        // 1234 + 4321 + 1, operands scrambled and start re-pulsed during RUN
        a16 = 16'h1234; b16 = 16'h4321; cin16 = 1'b1; start16 = 1'b1;
        step();
        start16 = 1'b0; a16 = 16'hAAAA; b16 = 16'hAAAA; cin16 = 1'b0;
        step();
        start16 = 1'b1;
        step();
        start16 = 1'b0;
        step();
        check("ignore_no_early_done", done16, 0);
        step();
        check("ignore_done", done16, 1);
        check("ignore_sum", sum16, 16'h5556);
        check("ignore_cout", cout16, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("ignore_single_done", done16, 0);
            check("ignore_idle_busy", busy16, 0);
        end
        check("ignore_sum_hold", sum16, 16'h5556);

        // 8000 + 8000, aborted by reset on the 3rd RUN cycle
        a16 = 16'h8000; b16 = 16'h8000; cin16 = 1'b0; start16 = 1'b1;
        step();
        start16 = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_busy", busy16, 0);
        check("abort_done", done16, 0);
        check("abort_sum",  sum16,  0);
        check("abort_cout", cout16, 0);
        for (int i = 0; i < 6; i++) begin
            step();
            check("abort_no_done", done16, 0);
        end

        // Back-to-back with start held high
        a16 = 16'h0F0F; b16 = 16'h00F1; cin16 = 1'b0; start16 = 1'b1;
        step();
        a16 = 16'h7FFF; b16 = 16'h7FFF; cin16 = 1'b1;
        n_dones = 0;
        for (int i = 1; i <= 14 && n_dones < 2; i++) begin
            step();
            if (done16) begin
                done_cyc[n_dones]  = i;
                done_sum[n_dones]  = sum16;
                done_cout[n_dones] = cout16;
                n_dones++;
            end
        end
        start16 = 1'b0;
        check("b2b_done_count", n_dones, 2);
        if (n_dones == 2) begin
            check("b2b_first_latency", done_cyc[0], 4);
            check("b2b_gap", done_cyc[1] - done_cyc[0], 5);
            check("b2b_sum0",  done_sum[0],  16'h1000);
            check("b2b_cout0", done_cout[0], 0);
            check("b2b_sum1",  done_sum[1],  16'hFFFF);
            check("b2b_cout1", done_cout[1], 0);
        end
        step();
        check("b2b_idle_busy", busy16, 0);
        check("b2b_idle_done", done16, 0);

        // WIDTH=4: F + F + 1, done one edge after acceptance
        a4 = 4'hF; b4 = 4'hF; cin4 = 1'b1; start4 = 1'b1;
        step();
        start4 = 1'b0;
        check("w4_run_busy", busy4, 1);
        check("w4_run_done", done4, 0);
        step();
        check("w4_done", done4, 1);
        check("w4_busy_at_done", busy4, 0);
        check("w4_sum", sum4, 4'hF);
        check("w4_cout", cout4, 1);
        step();
        check("w4_done_falls", done4, 0);

        // WIDTH=4: 3 + 4 + 0, no carry
        a4 = 4'h3; b4 = 4'h4; cin4 = 1'b0; start4 = 1'b1;
        step();
        start4 = 1'b0;
        step();
        check("w4b_done", done4, 1);
        check("w4b_sum", sum4, 4'h7);
        check("w4b_cout", cout4, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
